// File: rtl/otbn_rf_bignum_param_if.sv
// Bus interface for the parametrised bignum wide-data register file.
// Carries the write ports (address, per-granule enable, integrity-encoded
// data, commit) and the read ports (enable, address, integrity-encoded
// data). The RF is the slave; the datapath/controller side is the master.
//   wr_addr_i       NumWr*AddrW  write address per port
//   wr_en_i         NumWr*Gran   per-port, per-granule write enable
//   wr_data_intg_i  NumWr*ExtW   write data with integrity
//   wr_commit_i     1            qualifies all writes
//   rd_en_i         NumRd        read enable per port
//   rd_addr_i       NumRd*AddrW  read address per port
//   rd_data_intg_o  NumRd*ExtW   read data, zero when the port is disabled
interface otbn_rf_bignum_param_if #(
  parameter int unsigned NumRegs = 32,
  parameter int unsigned WordW   = 256,
  parameter int unsigned NumRd   = 2,
  parameter int unsigned NumWr   = 2
);
  localparam int unsigned Gran  = WordW / 32;
  localparam int unsigned ExtW  = Gran * 39;
  localparam int unsigned AddrW = $clog2(NumRegs);

  logic [NumWr*AddrW-1:0] wr_addr_i;
  logic [NumWr*Gran-1:0]  wr_en_i;
  logic [NumWr*ExtW-1:0]  wr_data_intg_i;
  logic                   wr_commit_i;
  logic [NumRd-1:0]       rd_en_i;
  logic [NumRd*AddrW-1:0] rd_addr_i;
  logic [NumRd*ExtW-1:0]  rd_data_intg_o;

  modport master (
    output wr_addr_i, wr_en_i, wr_data_intg_i, wr_commit_i, rd_en_i, rd_addr_i,
    input  rd_data_intg_o
  );

  modport slave (
    input  wr_addr_i, wr_en_i, wr_data_intg_i, wr_commit_i, rd_en_i, rd_addr_i,
    output rd_data_intg_o
  );
endinterface

// File: rtl/otbn_rf_bignum_param.sv
// Parametrised OTBN bignum wide-data register file.
// Storage is NumRegs x Gran granules of inverted SECDED(39,32) words.
// Reads are combinational and blanked when disabled or while wiping; every
// enabled read is integrity-checked and failures set a sticky error. A
// built-in sequencer wipes all registers with random data, then zeros.
//   clk_i              clock
//   rst_i              synchronous active-high reset
//   bus                read/write ports (otbn_rf_bignum_param_if.slave)
//   wipe_req_i         single-cycle wipe start request
//   wipe_rnd_i         raw random data for the random wipe pass
//   wipe_busy_o        wipe in progress
//   wipe_done_o        one-cycle pulse when the wipe completes
//   intg_err_o         sticky integrity error
//   wr_conflict_err_o  one-cycle pulse on a same-granule write collision
module otbn_rf_bignum_param #(
  parameter int unsigned NumRegs = 32,
  parameter int unsigned WordW   = 256,
  parameter int unsigned NumRd   = 2,
  parameter int unsigned NumWr   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  otbn_rf_bignum_param_if.slave bus,
  input  logic                  wipe_req_i,
  input  logic [WordW-1:0]      wipe_rnd_i,
  output logic                  wipe_busy_o,
  output logic                  wipe_done_o,
  output logic                  intg_err_o,
  output logic                  wr_conflict_err_o
);
  localparam int unsigned Gran  = WordW / 32;
  localparam int unsigned AddrW = $clog2(NumRegs);
  localparam logic [AddrW-1:0] LastReg  = AddrW'(NumRegs - 1);
  localparam logic [38:0]      ZeroWord = 39'h2A00000000;

  typedef enum logic [1:0] {Idle, WipeRnd, WipeZero} state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] cnt_q, cnt_d;
  logic [38:0]      mem_q [NumRegs][Gran];
  logic [38:0]      mem_d [NumRegs][Gran];
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             conf_q, conf_d;
  logic             idle;

  function automatic logic [38:0] secded_enc(input logic [31:0] d);
    logic [38:0] w;
    w     = {7'd0, d};
    w[32] = ^(w & 39'h002606BD25);
    w[33] = ^(w & 39'h00DEBA8050);
    w[34] = ^(w & 39'h00413D89AA);
    w[35] = ^(w & 39'h0031234ED1);
    w[36] = ^(w & 39'h00C2C1323B);
    w[37] = ^(w & 39'h002DCC624C);
    w[38] = ^(w & 39'h0098505586);
    return w ^ ZeroWord;
  endfunction

  // Nonzero syndrome means the decoder flags a single or double error.
  function automatic logic [6:0] secded_syn(input logic [38:0] w);
    logic [38:0] x;
    logic [6:0]  s;
    x    = w ^ ZeroWord;
    s[0] = ^(x & 39'h012606BD25);
    s[1] = ^(x & 39'h02DEBA8050);
    s[2] = ^(x & 39'h04413D89AA);
    s[3] = ^(x & 39'h0831234ED1);
    s[4] = ^(x & 39'h10C2C1323B);
    s[5] = ^(x & 39'h202DCC624C);
    s[6] = ^(x & 39'h4098505586);
    return s;
  endfunction

  assign idle = (state_q == Idle);

  // Storage and wipe sequencing. Ports are applied in ascending order so the
  // highest-index port wins a same-granule collision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    mem_d   = mem_q;
    unique case (state_q)
      Idle: begin
        if (bus.wr_commit_i) begin
          for (int unsigned p = 0; p < NumWr; p++) begin
            for (int unsigned g = 0; g < Gran; g++) begin
              if (bus.wr_en_i[p*Gran+g]) begin
                mem_d[bus.wr_addr_i[p*AddrW +: AddrW]][g] =
                  bus.wr_data_intg_i[(p*Gran+g)*39 +: 39];
              end
            end
          end
        end
        if (wipe_req_i) begin
          state_d = WipeRnd;
          cnt_d   = '0;
        end
      end
      WipeRnd: begin
        for (int unsigned g = 0; g < Gran; g++) begin
          mem_d[cnt_q][g] = secded_enc(wipe_rnd_i[g*32 +: 32]);
        end
        cnt_d = cnt_q + AddrW'(1);
        if (cnt_q == LastReg) begin
          cnt_d   = '0;
          state_d = WipeZero;
        end
      end
      WipeZero: begin
        for (int unsigned g = 0; g < Gran; g++) begin
          mem_d[cnt_q][g] = ZeroWord;
        end
        cnt_d = cnt_q + AddrW'(1);
        if (cnt_q == LastReg) begin
          cnt_d   = '0;
          state_d = Idle;
          done_d  = 1'b1;
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_comb begin
    conf_d = 1'b0;
    if (idle && bus.wr_commit_i) begin
      for (int unsigned a = 0; a < NumWr; a++) begin
        for (int unsigned b = a + 1; b < NumWr; b++) begin
          for (int unsigned g = 0; g < Gran; g++) begin
            if (bus.wr_en_i[a*Gran+g] && bus.wr_en_i[b*Gran+g] &&
                (bus.wr_addr_i[a*AddrW +: AddrW] == bus.wr_addr_i[b*AddrW +: AddrW])) begin
              conf_d = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (idle) begin
      for (int unsigned r = 0; r < NumRd; r++) begin
        if (bus.rd_en_i[r]) begin
          for (int unsigned g = 0; g < Gran; g++) begin
            if (secded_syn(mem_q[bus.rd_addr_i[r*AddrW +: AddrW]][g]) != '0) begin
              err_d = 1'b1;
            end
          end
        end
      end
    end
    if (done_d) begin
      err_d = 1'b0;
    end
  end

  always_comb begin
    bus.rd_data_intg_o = '0;
    for (int unsigned r = 0; r < NumRd; r++) begin
      if (idle && bus.rd_en_i[r]) begin
        for (int unsigned g = 0; g < Gran; g++) begin
          bus.rd_data_intg_o[(r*Gran+g)*39 +: 39] =
            mem_q[bus.rd_addr_i[r*AddrW +: AddrW]][g];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Idle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      conf_q  <= 1'b0;
      for (int unsigned i = 0; i < NumRegs; i++) begin
        for (int unsigned g = 0; g < Gran; g++) begin
          mem_q[i][g] <= ZeroWord;
        end
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      conf_q  <= conf_d;
      mem_q   <= mem_d;
    end
  end

  assign wipe_busy_o       = !idle;
  assign wipe_done_o       = done_q;
  assign intg_err_o        = err_q;
  assign wr_conflict_err_o = conf_q;
endmodule
